xcorr_feeder: RTL and testbench
===============================

XCORR_FEEDER -- requirements
Module: xcorr_feeder

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 Parameter DATA_W, default 16, sample and operand width.
REQ-003 Parameter N, default 16, samples per stream per frame; legal range 2..64.
REQ-004 Parameter LAGS, default 4, number of lags computed; legal range 1..N.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle frame start request.
REQ-008 s_valid  input  1  sample pair valid.
REQ-009 s_ready  output  1  block accepts a sample pair.
REQ-010 s_a  input  DATA_W  sample of stream A.
REQ-011 s_b  input  DATA_W  sample of stream B.
REQ-012 mac_en  output  1  operand pair valid; drives the MAC enable.
REQ-013 mac_a  output  DATA_W  first MAC operand.
REQ-014 mac_b  output  DATA_W  second MAC operand.
REQ-015 mac_clr  output  1  marks the first pair of a lag; the MAC restarts its accumulation.
REQ-016 mac_last  output  1  marks the final pair of a lag.
REQ-017 lag_idx  output  clog2(LAGS)+1  lag of the current pair.
REQ-018 busy  output  1  high in LOAD, RUN and DONE.
REQ-019 done  output  1  one-cycle frame-complete pulse.

Function
REQ-020 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-021 IDLE: start=1 -> LOAD on the next cycle; start is ignored in every other state.
REQ-022 LOAD: s_ready=1; each cycle with s_valid=1 writes s_a to a_buf[wr] and s_b to b_buf[wr], then wr++; s_valid=0 leaves wr unchanged.
REQ-023 LOAD -> RUN in the cycle after the N-th write; s_ready=0 outside LOAD, and s_valid is then ignored.
REQ-024 RUN: for k=0..LAGS-1 and i=0..N-1-k, issue exactly one pair per cycle, in order: mac_a=a_buf[i+k], mac_b=b_buf[i], lag_idx=k.
REQ-025 mac_clr=1 when i=0; mac_last=1 when i=N-1-k; both are 0 otherwise.
REQ-026 All mac_* outputs and lag_idx SHALL be registered; mac_a, mac_b and lag_idx are 0 whenever mac_en=0.
REQ-027 RUN lasts sum over k=0..LAGS-1 of (N-k) cycles with mac_en=1 continuously; for N=16 and LAGS=4 this is 58 cycles.
REQ-028 After the last pair of lag LAGS-1 -> DONE for one cycle with done=1, then IDLE.
REQ-029 Buffers retain their contents in IDLE; a new frame overwrites them fully.
REQ-030 Index arithmetic is unsigned; i+k never exceeds N-1, so no wrap-around.

Reset
REQ-031 rst=1 at any clock edge, including mid-LOAD and mid-RUN: state=IDLE and wr, i and k cleared.
REQ-032 Reset values: s_ready=0, mac_en=0, mac_a=0, mac_b=0, mac_clr=0, mac_last=0, lag_idx=0, busy=0, done=0.
REQ-033 Reset does not clear the buffer contents; rst has priority over start.

Configuration
REQ-034 Macro XCORR_FEEDER_HOLD_EN defined: adds input port hold (1 bit).
REQ-035 With the macro defined, hold=1 in RUN means the next cycle issues no pair (mac_en=0), i and k are frozen, and issue resumes in order once hold=0; hold is ignored in other states.
REQ-036 Macro undefined: no hold port, and RUN never stalls.

Verification
REQ-037 N=16, LAGS=4, a[j]=j+1, b[j]=0x10+j, start, 16 back-to-back writes -> 58 mac_en cycles; first pair (1,0x10) with clr=1; pair 16 (16,0x1F) with last=1; pair 17 (2,0x10) with lag_idx=1 and clr=1; done one cycle after the final pair (16,0x1C).
REQ-038 LOAD with s_valid toggling 1,0,1,0 -> only valid cycles are written; RUN starts exactly one cycle after the 16th accepted pair.
REQ-039 start pulsed during RUN -> ignored; pair sequence and count unchanged; a single done pulse.
REQ-040 rst at RUN pair 30 -> next cycle all outputs at reset values; a new start plus 16 writes yields a clean 58-pair frame.
REQ-041 N=2, LAGS=2 -> pairs (a0,b0,clr), (a1,b1,last), (a1,b0,clr+last,lag 1), then done.
REQ-042 XCORR_FEEDER_HOLD_EN defined, hold=1 for 3 cycles at pair 5 -> 3 cycles with mac_en=0, pair 6 issued next, 61 RUN cycles total.

Source files
------------

// File: rtl/xcorr_feeder.sv
// Operand sequencer for a cross-correlation MAC: buffers one frame of A/B samples, then streams
// a[i+k]/b[i] pairs for each lag k. Define XCORR_FEEDER_HOLD_EN to add a RUN-stall input (hold).
module xcorr_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 16,
  parameter int unsigned LAGS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_a,
  input  logic [DATA_W-1:0]       s_b,
`ifdef XCORR_FEEDER_HOLD_EN
  input  logic                    hold,
`endif
  output logic                    mac_en,
  output logic [DATA_W-1:0]       mac_a,
  output logic [DATA_W-1:0]       mac_b,
  output logic                    mac_clr,
  output logic                    mac_last,
  output logic [$clog2(LAGS):0]   lag_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned LW = $clog2(LAGS) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [AW-1:0]     wr;
  logic [AW-1:0]     i_cnt;
  logic [AW-1:0]     k_cnt;
  logic [AW-1:0]     ni;
  logic [AW-1:0]     nk;
  logic [AW-1:0]     rd_a;
  logic [DATA_W-1:0] a_buf [N];
  logic [DATA_W-1:0] b_buf [N];
  logic              stall;
  logic              lag_end;
  logic              frame_end;
  logic              last_wr;
  logic              issue;

`ifdef XCORR_FEEDER_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  assign busy    = (state != IDLE);
  assign s_ready = (state == LOAD);

  // i_cnt/k_cnt hold the pair most recently issued; ni/nk is the pair to issue next.
  always_comb begin
    lag_end   = (32'(i_cnt) + 32'(k_cnt) == N - 1);
    frame_end = lag_end && (32'(k_cnt) == LAGS - 1);
    last_wr   = (32'(wr) == N - 1);
    ni        = i_cnt;
    nk        = k_cnt;
    if (state == LOAD) begin
      ni = '0;
      nk = '0;
    end else if (lag_end) begin
      ni = '0;
      nk = k_cnt + 1'b1;
    end else begin
      ni = i_cnt + 1'b1;
    end
    rd_a  = ni + nk;
    issue = (state == LOAD && s_valid && last_wr) || (state == RUN && !stall && !frame_end);
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && s_valid) begin
      a_buf[wr] <= s_a;
      b_buf[wr] <= s_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr       <= '0;
      i_cnt    <= '0;
      k_cnt    <= '0;
      mac_en   <= 1'b0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_clr  <= 1'b0;
      mac_last <= 1'b0;
      lag_idx  <= '0;
      done     <= 1'b0;
    end else begin
      mac_en   <= 1'b0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_clr  <= 1'b0;
      mac_last <= 1'b0;
      lag_idx  <= '0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            wr    <= '0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            wr <= wr + 1'b1;
            if (last_wr) begin
              state <= RUN;
              wr    <= '0;
            end
          end
        end
        RUN: begin
          if (!stall && frame_end) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (issue) begin
        mac_en   <= 1'b1;
        mac_a    <= a_buf[rd_a];
        mac_b    <= b_buf[ni];
        mac_clr  <= (ni == '0);
        mac_last <= (32'(ni) + 32'(nk) == N - 1);
        lag_idx  <= LW'(nk);
        i_cnt    <= ni;
        k_cnt    <= nk;
      end
    end
  end

endmodule

// File: tb/tb_xcorr_feeder.sv
// Self-checking bench for xcorr_feeder: random frames against a queue-based reference of the
// expected operand stream, plus a directed N=2/LAGS=2 instance.
module tb_xcorr_feeder;
  localparam int DW   = 16;
  localparam int N    = 16;
  localparam int LAGS = 4;
  localparam int LW   = 3;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          clr;
    logic          last;
    logic [LW-1:0] lag;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, s_valid, s_ready, mac_en, mac_clr, mac_last, busy, done;
  logic [DW-1:0] s_a, s_b, mac_a, mac_b;
  logic [LW-1:0] lag_idx;
`ifdef XCORR_FEEDER_HOLD_EN
  logic          hold;
`endif

  logic          start2, s_valid2, s_ready2, mac_en2, clr2, last2, busy2, done2;
  logic [DW-1:0] s_a2, s_b2, mac_a2, mac_b2;
  logic [1:0]    lag2;

  xcorr_feeder #(.DATA_W(DW), .N(N), .LAGS(LAGS)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b),
`ifdef XCORR_FEEDER_HOLD_EN
    .hold(hold),
`endif
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_last(mac_last),
    .lag_idx(lag_idx), .busy(busy), .done(done)
  );

  xcorr_feeder #(.DATA_W(DW), .N(2), .LAGS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_a(s_a2), .s_b(s_b2),
`ifdef XCORR_FEEDER_HOLD_EN
    .hold(1'b0),
`endif
    .mac_en(mac_en2), .mac_a(mac_a2), .mac_b(mac_b2), .mac_clr(clr2), .mac_last(last2),
    .lag_idx(lag2), .busy(busy2), .done(done2)
  );

  int            checks = 0;
  int            passed = 0;
  logic [DW-1:0] ma [N];
  logic [DW-1:0] mb [N];
  pair_t         exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check(tag, 64'({s_ready, mac_en, mac_a, mac_b, mac_clr, mac_last, lag_idx, busy, done}), '0);
  endtask

  // Reference: every lag k pairs a[i+k] with b[i] for i = 0..N-1-k.
  task automatic build_model();
    pair_t p;
    exp_q.delete();
    for (int k = 0; k < LAGS; k++) begin
      for (int i = 0; i <= N - 1 - k; i++) begin
        p.a    = ma[i + k];
        p.b    = mb[i];
        p.clr  = (i == 0);
        p.last = (i == N - 1 - k);
        p.lag  = LW'(k);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < N; j++) begin
      ma[j] = DW'($urandom);
      mb[j] = DW'($urandom);
    end
  endtask

  task automatic load(input bit toggle);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_entry", 64'({busy, s_ready}), 64'(2'b11));
    for (int j = 0; j < N; j++) begin
      s_valid = 1'b1;
      s_a = ma[j];
      s_b = mb[j];
      @(negedge clk);
      if (toggle && j != N - 1) begin
        s_valid = 1'b0;
        s_a = DW'($urandom);
        s_b = DW'($urandom);
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    check("run_starts_after_last_write", 64'({s_ready, mac_en}), 64'(2'b01));
  endtask

  task automatic collect(input int start_at, input int rst_at, input int hold_at,
                         output int npairs, output int nrun, output int ndone, output int nstall);
    int idx = 0;
    bit fin = 1'b0;
    bit prev_final = 1'b0;
    int hcnt = 0;
    nrun = 0;
    ndone = 0;
    nstall = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (done) begin
        ndone++;
        check("done_after_final_pair", 64'(prev_final), 64'(1));
      end
      if (!busy) begin
        fin = 1'b1;
      end else if (mac_en) begin
        if (idx < exp_q.size())
          check("pair", 64'({mac_a, mac_b, mac_clr, mac_last, lag_idx}), 64'(exp_q[idx]));
        else
          check("extra_pair", 64'(idx), 64'(exp_q.size()));
        idx++;
      end else begin
        check("idle_outputs_zero", 64'({mac_a, mac_b, mac_clr, mac_last, lag_idx}), '0);
        if (!done) nstall++;
      end
      if (busy && !done) nrun++;
      prev_final = mac_en && (idx == exp_q.size());
      start = mac_en && (idx == start_at);
      if (mac_en && idx == hold_at) hcnt = 3;
`ifdef XCORR_FEEDER_HOLD_EN
      hold = (hcnt > 0);
`endif
      if (hcnt > 0) hcnt--;
      if (rst_at > 0 && mac_en && idx == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset("reset_mid_run");
        rst = 1'b0;
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) check("frame_timeout", 64'(fin), 64'(1));
    npairs = idx;
    start = 1'b0;
`ifdef XCORR_FEEDER_HOLD_EN
    hold = 1'b0;
`endif
  endtask

  task automatic run_frame(input bit toggle, input int start_at, input int rst_at,
                           input int hold_at, input int exp_stall);
    int np, nr, nd, ns;
    build_model();
    load(toggle);
    collect(start_at, rst_at, hold_at, np, nr, nd, ns);
    if (rst_at < 0) begin
      check("pair_count", 64'(np), 64'(exp_q.size()));
      check("done_count", 64'(nd), 64'(1));
      check("run_cycles", 64'(nr), 64'(exp_q.size() + exp_stall));
      check("stall_cycles", 64'(ns), 64'(exp_stall));
    end
  endtask

  initial begin
    logic [DW-1:0] a0, a1, b0, b1;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
    start2 = 1'b0; s_valid2 = 1'b0; s_a2 = '0; s_b2 = '0;
`ifdef XCORR_FEEDER_HOLD_EN
    hold = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;

    for (int j = 0; j < N; j++) begin
      ma[j] = DW'(j + 1);
      mb[j] = DW'(16'h10 + j);
    end
    run_frame(1'b0, -1, -1, -1, 0);

    fill_random();
    run_frame(1'b1, 10, -1, -1, 0);

    fill_random();
    run_frame(1'b0, -1, 30, -1, 0);
    fill_random();
    run_frame(1'b0, -1, -1, -1, 0);

`ifdef XCORR_FEEDER_HOLD_EN
    fill_random();
    run_frame(1'b0, -1, -1, 5, 3);
`endif

    a0 = DW'($urandom); a1 = DW'($urandom); b0 = DW'($urandom); b1 = DW'($urandom);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    s_valid2 = 1'b1; s_a2 = a0; s_b2 = b0;
    @(negedge clk);
    s_a2 = a1; s_b2 = b1;
    @(negedge clk);
    s_valid2 = 1'b0;
    check("n2_pair0", 64'({mac_en2, mac_a2, mac_b2, clr2, last2, lag2}),
          64'({1'b1, a0, b0, 1'b1, 1'b0, 2'd0}));
    @(negedge clk);
    check("n2_pair1", 64'({mac_en2, mac_a2, mac_b2, clr2, last2, lag2}),
          64'({1'b1, a1, b1, 1'b0, 1'b1, 2'd0}));
    @(negedge clk);
    check("n2_pair2", 64'({mac_en2, mac_a2, mac_b2, clr2, last2, lag2}),
          64'({1'b1, a1, b0, 1'b1, 1'b1, 2'd1}));
    @(negedge clk);
    check("n2_done", 64'({done2, mac_en2, busy2}), 64'(3'b101));
    @(negedge clk);
    check("n2_idle", 64'({done2, busy2, s_ready2}), '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
